// File: rtl/iter_div.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero short path and cancel support for the EX pipeline stage.
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata_1_i,
    input  logic [WIDTH-1:0]   opdata_2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    // state   | meaning
    // FREE    | idle, waiting for start_i without annul_i
    // BY_ZERO | divisor was zero, result is forced to 0
    // ON      | restoring steps in progress, count = steps done
    // END     | result_o valid, held until start_i drops

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic             neg_q, neg_r;
    logic             accept;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   part, diff;
    logic             step_ge;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign accept = start_i && !annul_i;
    assign a_abs  = (signed_i && opdata_1_i[WIDTH-1]) ? -opdata_1_i : opdata_1_i;
    assign b_abs  = (signed_i && opdata_2_i[WIDTH-1]) ? -opdata_2_i : opdata_2_i;

    // rem < dvs always holds, so part < 2*dvs and bit WIDTH of diff is the borrow.
    assign part    = {rem, quo[WIDTH-1]};
    assign diff    = part - {1'b0, dvs};
    assign step_ge = ~diff[WIDTH];

    assign quo_fix = neg_q ? -quo : quo;
    assign rem_fix = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FREE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE:    if (accept) state_nxt = (opdata_2_i == '0) ? BY_ZERO : ON;
            BY_ZERO: state_nxt = annul_i ? FREE : END;
            ON: begin
                if (annul_i)                state_nxt = FREE;
                else if (count == CNT_LAST) state_nxt = END;
            end
            END:     if (!start_i) state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    count    <= '0;
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept) begin
                        quo   <= a_abs;
                        rem   <= '0;
                        dvs   <= b_abs;
                        neg_q <= signed_i && (opdata_1_i[WIDTH-1] ^ opdata_2_i[WIDTH-1]);
                        neg_r <= signed_i && opdata_1_i[WIDTH-1];
                    end
                end
                BY_ZERO: begin
                    count    <= '0;
                    result_o <= '0;
                    ready_o  <= !annul_i;
                end
                ON: begin
                    if (annul_i) begin
                        count    <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else if (count != CNT_LAST) begin
                        quo   <= {quo[WIDTH-2:0], step_ge};
                        rem   <= step_ge ? diff[WIDTH-1:0] : part[WIDTH-1:0];
                        count <= count + CNT_W'(1);
                    end else begin
                        count    <= '0;
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
